// File: rtl/watch_pkg.sv
// Shared watch definitions: field indices, packed time layout and calendar rules.
// Used by the time counter and the time setter so both agree on month lengths.
package watch_pkg;

    typedef logic [2:0] field_t;

    localparam field_t FLD_YEAR   = 3'd0;
    localparam field_t FLD_MONTH  = 3'd1;
    localparam field_t FLD_DAY    = 3'd2;
    localparam field_t FLD_HOUR   = 3'd3;
    localparam field_t FLD_MINUTE = 3'd4;
    localparam field_t FLD_SECOND = 3'd5;

    // Packing order of bin_time, MSB first.
    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } time_t;

    // Year y encodes 2000+y.
    function automatic logic is_leap(input logic [7:0] y);
        int full;
        full = 2000 + int'(y);
        return ((full % 4 == 0) && (full % 100 != 0)) || (full % 400 == 0);
    endfunction

    // Returns 0 for an illegal month.
    function automatic logic [7:0] max_date(input logic [7:0] y,
                                            input logic [7:0] m);
        logic [7:0] r;
        case (m)
            8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: r = 8'd31;
            8'd4, 8'd6, 8'd9, 8'd11:                    r = 8'd30;
            8'd2:    r = is_leap(y) ? 8'd29 : 8'd28;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/time_setter_if.sv
// Button / live-time / load-port bundle of the time setter.
// master: button block + time counter side; slave: time_setter.
interface time_setter_if;
    logic        clk1sec;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic [7:0]  cur_year;
    logic [7:0]  cur_month;
    logic [7:0]  cur_day;
    logic [7:0]  cur_hour;
    logic [7:0]  cur_minute;
    logic [7:0]  cur_second;
    logic [47:0] bin_time;
    logic        set_time;
    logic        edit_active;
    logic [2:0]  field_sel;
    logic        blink;

    modport master (
        output clk1sec, btn_mode, btn_up, btn_down,
        output cur_year, cur_month, cur_day,
        output cur_hour, cur_minute, cur_second,
        input  bin_time, set_time, edit_active, field_sel, blink
    );

    modport slave (
        input  clk1sec, btn_mode, btn_up, btn_down,
        input  cur_year, cur_month, cur_day,
        input  cur_hour, cur_minute, cur_second,
        output bin_time, set_time, edit_active, field_sel, blink
    );
endinterface

// File: rtl/month_days.sv
// Combinational days-in-month lookup.
// Ports: year[7:0] (2000+year), month[7:0] in; max_date[7:0] out, 0 if month illegal.
module month_days
    import watch_pkg::*;
(
    input  logic [7:0] year,
    input  logic [7:0] month,
    output logic [7:0] max_date
);
    assign max_date = watch_pkg::max_date(year, month);
endmodule

// File: rtl/time_setter.sv
// Interactive time editor: snapshots live time, edits a shadow copy, commits it.
// Ports: clk, rst (sync, active-high), bus (time_setter_if.slave).
module time_setter
    import watch_pkg::*;
#(
    parameter int TIMEOUT_SEC = 30
) (
    input logic          clk,
    input logic          rst,
    time_setter_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_COMMIT
    } state_t;

    state_t          state_q;
    time_t           shadow_q;
    time_t           edit_d;
    time_t           bin_time_q;
    field_t          field_q;
    logic [TO_W-1:0] to_q;
    logic            set_time_q;
    logic            edit_active_q;
    logic            blink_q;

    logic       inc;
    logic       dec;
    logic       step;
    logic       any_btn;
    logic [7:0] year_d;
    logic [7:0] month_d;
    logic [7:0] md;

    assign inc     = bus.btn_up & ~bus.btn_down;
    assign dec     = bus.btn_down & ~bus.btn_up;
    assign step    = inc | dec;
    assign any_btn = bus.btn_mode | bus.btn_up | bus.btn_down;

    // Year/month are resolved first so the day limit reflects the new values.
    always_comb begin
        year_d  = shadow_q.year;
        month_d = shadow_q.month;
        if (step && field_q == FLD_YEAR) begin
            year_d = inc ? shadow_q.year + 8'd1 : shadow_q.year - 8'd1;
        end
        if (step && field_q == FLD_MONTH) begin
            if (inc) begin
                month_d = (shadow_q.month >= 8'd12) ? 8'd1 : shadow_q.month + 8'd1;
            end else begin
                month_d = (shadow_q.month <= 8'd1) ? 8'd12 : shadow_q.month - 8'd1;
            end
        end
    end

    month_days u_md (
        .year     (year_d),
        .month    (month_d),
        .max_date (md)
    );

    always_comb begin
        edit_d       = shadow_q;
        edit_d.year  = year_d;
        edit_d.month = month_d;
        if (step) begin
            case (field_q)
                FLD_YEAR, FLD_MONTH: begin
                    // Clamp only when the calendar actually changed.
                    if (shadow_q.day > md) edit_d.day = md;
                end
                FLD_DAY: begin
                    if (inc) begin
                        edit_d.day = (shadow_q.day >= md) ? 8'd1 : shadow_q.day + 8'd1;
                    end else begin
                        edit_d.day = (shadow_q.day <= 8'd1) ? md : shadow_q.day - 8'd1;
                    end
                end
                FLD_HOUR: begin
                    if (inc) begin
                        edit_d.hour = (shadow_q.hour >= 8'd23) ? 8'd0 : shadow_q.hour + 8'd1;
                    end else begin
                        edit_d.hour = (shadow_q.hour == 8'd0) ? 8'd23 : shadow_q.hour - 8'd1;
                    end
                end
                FLD_MINUTE: begin
                    if (inc) begin
                        edit_d.minute = (shadow_q.minute >= 8'd59) ? 8'd0 : shadow_q.minute + 8'd1;
                    end else begin
                        edit_d.minute = (shadow_q.minute == 8'd0) ? 8'd59 : shadow_q.minute - 8'd1;
                    end
                end
                FLD_SECOND: begin
                    if (inc) begin
                        edit_d.second = (shadow_q.second >= 8'd59) ? 8'd0 : shadow_q.second + 8'd1;
                    end else begin
                        edit_d.second = (shadow_q.second == 8'd0) ? 8'd59 : shadow_q.second - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            bin_time_q    <= '0;
            field_q       <= FLD_YEAR;
            to_q          <= '0;
            set_time_q    <= 1'b0;
            edit_active_q <= 1'b0;
            blink_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    set_time_q <= 1'b0;
                    blink_q    <= 1'b0;
                    if (bus.btn_mode) begin
                        shadow_q      <= {bus.cur_year, bus.cur_month, bus.cur_day,
                                          bus.cur_hour, bus.cur_minute, bus.cur_second};
                        field_q       <= FLD_YEAR;
                        to_q          <= '0;
                        edit_active_q <= 1'b1;
                        state_q       <= S_EDIT;
                    end
                end
                S_EDIT: begin
                    if (bus.clk1sec) blink_q <= ~blink_q;
                    if (bus.btn_mode) begin
                        to_q <= '0;
                        if (field_q == FLD_SECOND) begin
                            bin_time_q    <= shadow_q;
                            set_time_q    <= 1'b1;
                            edit_active_q <= 1'b0;
                            blink_q       <= 1'b0;
                            state_q       <= S_COMMIT;
                        end else begin
                            field_q <= field_q + 3'd1;
                        end
                    end else if (any_btn) begin
                        to_q     <= '0;
                        shadow_q <= edit_d;
                    end else if (bus.clk1sec) begin
                        if (to_q == TO_LAST) begin
                            to_q          <= '0;
                            field_q       <= FLD_YEAR;
                            edit_active_q <= 1'b0;
                            blink_q       <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            to_q <= to_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    set_time_q <= 1'b0;
                    field_q    <= FLD_YEAR;
                    state_q    <= S_IDLE;
                end
                default: begin
                    set_time_q    <= 1'b0;
                    edit_active_q <= 1'b0;
                    blink_q       <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bin_time    = bin_time_q;
    assign bus.set_time    = set_time_q;
    assign bus.edit_active = edit_active_q;
    assign bus.field_sel   = field_q;
    assign bus.blink       = blink_q;

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: vector table, commit scoreboard,
// and hand sequences for timeout, reset, commit timing and simultaneous buttons.
module tb_time_setter;
    import watch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_setter_if ifc ();

    time_setter #(.TIMEOUT_SEC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_sets   = 0;
    logic [47:0] exp_q[$];

    typedef struct {
        logic [47:0] cur;
        int          fld;
        int          ups;
        int          downs;
        logic [47:0] exp;
    } vec_t;

    vec_t vt[15];

    function automatic logic [47:0] pk(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    task automatic check(input string name, input logic [47:0] act,
                         input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_cur(input logic [47:0] t);
        {ifc.cur_year, ifc.cur_month, ifc.cur_day,
         ifc.cur_hour, ifc.cur_minute, ifc.cur_second} = t;
    endtask

    // Called at a negedge; the pulse is sampled at the next posedge and
    // the task returns on the following negedge with outputs updated.
    task automatic press(input logic m, input logic u, input logic d,
                         input logic t);
        ifc.btn_mode = m;
        ifc.btn_up   = u;
        ifc.btn_down = d;
        ifc.clk1sec  = t;
        @(negedge clk);
        ifc.btn_mode = 1'b0;
        ifc.btn_up   = 1'b0;
        ifc.btn_down = 1'b0;
        ifc.clk1sec  = 1'b0;
    endtask

    // Commit scoreboard.
    always @(negedge clk) begin
        if (ifc.set_time === 1'b1) begin
            n_sets++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_set_time: got bin_time %0h required no strobe",
                         ifc.bin_time);
            end else begin
                check("commit_bin_time", ifc.bin_time, exp_q.pop_front());
            end
        end
    end

    initial begin
        int s0;
        vt[0]  = '{pk(21, 3, 31, 10, 20, 30), 1, 0, 1, pk(21, 2, 28, 10, 20, 30)};
        vt[1]  = '{pk(24, 3, 31, 10, 20, 30), 1, 0, 1, pk(24, 2, 29, 10, 20, 30)};
        vt[2]  = '{pk(100, 3, 31, 1, 2, 3),   1, 0, 1, pk(100, 2, 28, 1, 2, 3)};
        vt[3]  = '{pk(0, 3, 31, 1, 2, 3),     1, 0, 1, pk(0, 2, 29, 1, 2, 3)};
        vt[4]  = '{pk(21, 5, 10, 23, 30, 0),  3, 1, 0, pk(21, 5, 10, 0, 30, 0)};
        vt[5]  = '{pk(21, 5, 10, 4, 0, 5),    4, 0, 1, pk(21, 5, 10, 4, 59, 5)};
        vt[6]  = '{pk(255, 1, 15, 1, 2, 3),   0, 1, 0, pk(0, 1, 15, 1, 2, 3)};
        vt[7]  = '{pk(21, 12, 15, 1, 2, 3),   1, 1, 0, pk(21, 1, 15, 1, 2, 3)};
        vt[8]  = '{pk(21, 1, 15, 1, 2, 3),    1, 0, 1, pk(21, 12, 15, 1, 2, 3)};
        vt[9]  = '{pk(21, 4, 1, 1, 2, 3),     2, 0, 1, pk(21, 4, 30, 1, 2, 3)};
        vt[10] = '{pk(21, 2, 28, 1, 2, 3),    2, 1, 0, pk(21, 2, 1, 1, 2, 3)};
        vt[11] = '{pk(21, 5, 10, 6, 7, 59),   5, 1, 0, pk(21, 5, 10, 6, 7, 0)};
        vt[12] = '{pk(24, 2, 29, 1, 2, 3),    0, 1, 0, pk(25, 2, 28, 1, 2, 3)};
        vt[13] = '{pk(21, 1, 31, 1, 2, 3),    1, 1, 0, pk(21, 2, 28, 1, 2, 3)};
        vt[14] = '{pk(22, 6, 29, 1, 2, 3),    2, 2, 0, pk(22, 6, 1, 1, 2, 3)};

        ifc.btn_mode = 1'b0;
        ifc.btn_up   = 1'b0;
        ifc.btn_down = 1'b0;
        ifc.clk1sec  = 1'b0;
        set_cur(pk(21, 5, 30, 12, 0, 0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_bin_time", ifc.bin_time, 48'd0);
        check("rst_set_time", 48'(ifc.set_time), 48'd0);
        check("rst_edit_active", 48'(ifc.edit_active), 48'd0);
        check("rst_field_sel", 48'(ifc.field_sel), 48'd0);
        check("rst_blink", 48'(ifc.blink), 48'd0);
        rst = 1'b0;
        @(negedge clk);

        // Up/down in IDLE must not start anything.
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_ignore_edit", 48'(ifc.edit_active), 48'd0);

        // Full edit sequence.
        set_cur(pk(21, 5, 30, 12, 0, 0));
        s0 = n_sets;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("full_enter_edit", 48'(ifc.edit_active), 48'd1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("full_field_day", 48'(ifc.field_sel), 48'd2);
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        check("full_field_sec", 48'(ifc.field_sel), 48'd5);
        exp_q.push_back(pk(23, 4, 30, 12, 0, 0));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("full_set_time_hi", 48'(ifc.set_time), 48'd1);
        check("full_edit_low", 48'(ifc.edit_active), 48'd0);
        // Mode during the COMMIT cycle is ignored.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("commit_mode_ignored", 48'(ifc.edit_active), 48'd0);
        check("full_set_time_lo", 48'(ifc.set_time), 48'd0);
        check("full_bin_hold", ifc.bin_time, pk(23, 4, 30, 12, 0, 0));
        @(negedge clk);
        check("full_one_strobe", 48'(n_sets - s0), 48'd1);

        // Table of single-field edits.
        for (int i = 0; i < 15; i++) begin
            set_cur(vt[i].cur);
            press(1'b1, 1'b0, 1'b0, 1'b0);
            check("vec_enter", 48'(ifc.edit_active), 48'd1);
            repeat (vt[i].fld) press(1'b1, 1'b0, 1'b0, 1'b0);
            check("vec_field", 48'(ifc.field_sel), 48'(vt[i].fld));
            repeat (vt[i].ups) press(1'b0, 1'b1, 1'b0, 1'b0);
            repeat (vt[i].downs) press(1'b0, 1'b0, 1'b1, 1'b0);
            s0 = n_sets;
            exp_q.push_back(vt[i].exp);
            repeat (6 - vt[i].fld) press(1'b1, 1'b0, 1'b0, 1'b0);
            check("vec_set_time", 48'(ifc.set_time), 48'd1);
            @(negedge clk);
            check("vec_strobe_len", 48'(ifc.set_time), 48'd0);
            check("vec_one_strobe", 48'(n_sets - s0), 48'd1);
        end

        // Timeout with no buttons.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("to_blink0", 48'(ifc.blink), 48'd0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("to_blink1", 48'(ifc.blink), 48'd1);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("to_blink2", 48'(ifc.blink), 48'd0);
        check("to_still_edit", 48'(ifc.edit_active), 48'd1);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("to_exit", 48'(ifc.edit_active), 48'd0);
        check("to_blink_idle", 48'(ifc.blink), 48'd0);
        repeat (2) @(negedge clk);

        // A button on the second tick postpones the timeout.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0, 1'b1);
        check("pp_blink_toggles", 48'(ifc.blink), 48'd0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("pp_still_edit", 48'(ifc.edit_active), 48'd1);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("pp_exit", 48'(ifc.edit_active), 48'd0);

        // Reset mid-edit at field 3, then re-snapshot.
        set_cur(pk(30, 7, 4, 5, 6, 7));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        check("rm_field3", 48'(ifc.field_sel), 48'd3);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rm_bin_time", ifc.bin_time, 48'd0);
        check("rm_edit", 48'(ifc.edit_active), 48'd0);
        check("rm_field", 48'(ifc.field_sel), 48'd0);
        check("rm_blink", 48'(ifc.blink), 48'd0);
        check("rm_set_time", 48'(ifc.set_time), 48'd0);
        set_cur(pk(31, 8, 9, 10, 11, 12));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        set_cur(pk(99, 9, 9, 9, 9, 9));
        exp_q.push_back(pk(31, 8, 9, 10, 11, 12));
        repeat (6) press(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Simultaneous buttons.
        set_cur(pk(50, 6, 15, 8, 9, 10));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check("sim_mode_up_field", 48'(ifc.field_sel), 48'd1);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(pk(50, 6, 15, 8, 9, 10));
        repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        check("scoreboard_drained", 48'(exp_q.size()), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_setter.md
# time_setter

User time-editing controller that drives the load port of the watch time counter. On a mode button it snapshots the running time into shadow registers and lets the user step through year, month, day, hour, minute and second with up/down buttons. Calendar rules are enforced on the shadow copy. On commit it presents the packed 48-bit time with a one-cycle `set_time` pulse. It sits between the debounced button block and the time counter and owns the whole interactive set sequence.

## Interface
- TIMEOUT_SEC, 30: seconds of button inactivity in EDIT before the edit is abandoned without commit.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk1sec  in  1  one-cycle tick per second, synchronous to clk.
- btn_mode  in  1  one-cycle pulse, already debounced; enter edit / next field / commit.
- btn_up  in  1  one-cycle pulse; increment the selected field.
- btn_down  in  1  one-cycle pulse; decrement the selected field.
- cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second  in  8 each  live time from the counter, binary.
- bin_time  out  48  {year,month,day,hour,minute,second}, MSB first; valid when set_time=1.
- set_time  out  1  one-cycle load strobe to the counter.
- edit_active  out  1  high while in EDIT.
- field_sel  out  3  selected field: 0=year, 1=month, 2=day, 3=hour, 4=minute, 5=second.
- blink  out  1  display blink phase for the selected field.

## Operation
- States: IDLE, EDIT, COMMIT.
- IDLE + btn_mode: copy cur_* into the shadow registers, field_sel=0, clear the timeout counter, go to EDIT. up/down are ignored in IDLE.
- EDIT + btn_mode with field_sel<5: field_sel+1. With field_sel=5: go to COMMIT.
- COMMIT, one cycle: set_time=1, bin_time=shadow, then return to IDLE.
- Per-cycle priority in EDIT: btn_mode > btn_up/btn_down. If btn_up and btn_down are both high, the field is unchanged.
- Field ranges, all wrap-around:
  - year 0..255, where year Y means 2000+Y
  - month 1..12
  - day 1..max_date
  - hour 0..23
  - minute 0..59
  - second 0..59
- Examples: up at 59 gives 0; down at 1 (month) gives 12; down at day 1 gives max_date.
- max_date is 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28+leap for month 2.
- leap = ((2000+Y)%4==0 && (2000+Y)%100!=0) || (2000+Y)%400==0. Year 0 is leap; 100 and 200 are not.
- Day clamp: after any year or month change, if shadow day > new max_date, the day becomes max_date in the same update.
- Timeout: a counter increments on clk1sec in EDIT and clears on any button pulse. When it reaches TIMEOUT_SEC, go to IDLE with no set_time.
- blink toggles on each clk1sec in EDIT; it is 0 in IDLE and COMMIT.
- bin_time holds its last committed value outside COMMIT.

## Timing
- Reset values: state IDLE, set_time=0, bin_time=0, edit_active=0, field_sel=0, blink=0, shadow=0, timeout=0.
- A button sampled at edge N takes effect in the registers and outputs after edge N; latency is 1 cycle.
- Commit: btn_mode at field 5 sampled at edge N; set_time=1 during cycle N+1; edit_active=0 from N+1; IDLE at N+2.
- btn_mode during COMMIT is ignored.
- rst in any state returns all registers to reset values on the next edge. No partial set_time is ever issued.
- A clk1sec and a button in the same cycle: the button wins and the timeout clears. blink still toggles.
- The counter keeps running during EDIT. The snapshot is taken once at entry and never refreshed.

## Structure
- Shared `watch_pkg`:
  - field-index constants
  - the packing order of bin_time
  - the max_date / leap-year function, so the time counter and this block use identical calendar rules
- Sub-module `month_days`: combinational; inputs year[7:0], month[7:0]; output max_date[7:0]; returns 0 for an illegal month.
- Remainder: one FSM, the shadow registers, and a timeout counter of width clog2(TIMEOUT_SEC+1).

## Test plan
- Full edit: cur=21/5/30 12:00:00; mode, up×2 (year 23), mode, down (month 4), mode, then mode×4 -> set_time once; bin_time={23,4,30,12,0,0}.
- Clamp: shadow day 31, month 3; step month down to 2 with year 21 -> day 28; with year 24 -> day 29; with year 100 -> day 28.
- Wrap: hour 23 + up -> 0; minute 0 + down -> 59; year 255 + up -> 0; month 12 + up -> 1.
- Timeout with TIMEOUT_SEC=3: enter EDIT, then 3 clk1sec with no buttons -> IDLE, set_time never asserted. A button at tick 2 postpones the exit.
- Reset mid-edit at field 3 -> all outputs 0 the next cycle; a following mode press re-snapshots cur_*.
- Simultaneous: up+down together -> no change; mode+up together -> field advances and the value is unchanged.
